// File: rtl/time_set_pkg.sv
// time_set_pkg: shared definitions for the clock-setting controller.
//   mode_e          : operating modes (NORMAL, SET_HOUR, SET_MIN; code 3 unused)
//   HOUR_MAX        : largest hour value (23)
//   MIN_MAX/SEC_MAX : largest minute/second value (59)
//   CLK_HZ_DEFAULT  : default input clock frequency in Hz
package time_set_pkg;

    typedef enum logic [1:0] {
        NORMAL   = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2
    } mode_e;

    localparam int HOUR_MAX       = 23;
    localparam int MIN_MAX        = 59;
    localparam int SEC_MAX        = 59;
    localparam int CLK_HZ_DEFAULT = 50_000_000;

endpackage

// File: rtl/mod_updown_cnt.sv
// mod_updown_cnt: modulo-MOD up/down counter with wrap-carry.
//   CLK   : clock, rising edge
//   RST   : asynchronous active-high reset, clears value
//   inc   : count up (wraps MOD-1 -> 0)
//   dec   : count down (wraps 0 -> MOD-1)
//   clr   : synchronous clear, overrides inc/dec
//   value : registered count, 0..MOD-1
//   carry : high in the cycle an increment wraps MOD-1 -> 0
// inc and dec together cancel and leave the value unchanged.
module mod_updown_cnt #(
    parameter int MOD = 60,
    parameter int W   = 6
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         inc,
    input  logic         dec,
    input  logic         clr,
    output logic [W-1:0] value,
    output logic         carry
);

    localparam logic [W-1:0] LAST = W'(MOD - 1);

    assign carry = inc & ~dec & ~clr & (value == LAST);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (inc && !dec) begin
            value <= (value == LAST) ? '0 : value + W'(1);
        end else if (dec && !inc) begin
            value <= (value == '0) ? LAST : value - W'(1);
        end
    end

endmodule

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: 24-hour time-of-day counter with button-driven set modes.
//   CLK   : system clock, rising edge
//   RST   : asynchronous active-high reset (time 00:00:00, NORMAL mode)
//   BTN   : single-cycle press pulses: [0] MODE, [1] UP, [2] DOWN
//   HOUR  : hours 0..23 (registered)
//   MIN   : minutes 0..59 (registered)
//   SEC   : seconds 0..59 (registered)
//   MODE  : 0 NORMAL, 1 SET_HOUR, 2 SET_MIN (registered)
//   BLINK : 2 Hz blank strobe for the field being set, 0 in NORMAL
// MODE presses advance NORMAL -> SET_HOUR -> SET_MIN -> NORMAL and take
// priority over UP/DOWN in the same cycle. Time only runs in NORMAL.
module time_set_ctrl
    import time_set_pkg::*;
#(
    parameter int CLK_HZ = CLK_HZ_DEFAULT
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [2:0] BTN,
    output logic [4:0] HOUR,
    output logic [5:0] MIN,
    output logic [5:0] SEC,
    output logic [1:0] MODE,
    output logic       BLINK
);

    localparam int PRESC_W   = $clog2(CLK_HZ);
    localparam int BLINK_DIV = CLK_HZ / 4;
    localparam int BLINK_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_HZ - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    mode_e               mode_q, mode_d;
    logic                mode_chg;
    logic                edit_up, edit_dn;
    logic [PRESC_W-1:0]  presc_q;
    logic [BLINK_W-1:0]  bcnt_q;
    logic                blink_q;
    logic                tick;
    logic                sec_clr, sec_carry;
    logic                min_inc, min_dec, min_carry;
    logic                hour_inc, hour_dec;
    // The day rollover 23:59:59 -> 00:00:00 feeds nothing further.
    logic                hour_carry_unused;

    // Mode FSM state register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mode_q <= NORMAL;
        end else begin
            mode_q <= mode_d;
        end
    end

    // Next mode; the unused code falls back to NORMAL on the next edge.
    always_comb begin
        mode_d = mode_q;
        case (mode_q)
            NORMAL:   if (BTN[0]) mode_d = SET_HOUR;
            SET_HOUR: if (BTN[0]) mode_d = SET_MIN;
            SET_MIN:  if (BTN[0]) mode_d = NORMAL;
            default:  mode_d = NORMAL;
        endcase
    end

    assign mode_chg = (mode_d != mode_q);

    // A MODE press swallows any UP/DOWN in the same cycle; UP+DOWN cancel.
    assign edit_up = BTN[1] & ~BTN[2] & ~BTN[0];
    assign edit_dn = BTN[2] & ~BTN[1] & ~BTN[0];

    // One-second prescaler, parked at 0 outside NORMAL so that re-entering
    // NORMAL gives a full second before the first SEC increment.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            presc_q <= '0;
        end else if (mode_q == NORMAL && !mode_chg) begin
            presc_q <= (presc_q == PRESC_LAST) ? '0 : presc_q + PRESC_W'(1);
        end else begin
            presc_q <= '0;
        end
    end

    assign tick = (mode_q == NORMAL) && (presc_q == PRESC_LAST);

    // Blink generator: restarts high on every mode change, then toggles
    // every CLK_HZ/4 cycles while a field is being set.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bcnt_q  <= '0;
            blink_q <= 1'b0;
        end else if (mode_d == NORMAL) begin
            bcnt_q  <= '0;
            blink_q <= 1'b0;
        end else if (mode_chg) begin
            bcnt_q  <= '0;
            blink_q <= 1'b1;
        end else if (bcnt_q == BLINK_LAST) begin
            bcnt_q  <= '0;
            blink_q <= ~blink_q;
        end else begin
            bcnt_q  <= bcnt_q + BLINK_W'(1);
        end
    end

    // Leaving SET_MIN restarts the minute at :00.
    assign sec_clr  = (mode_q == SET_MIN) && BTN[0];

    // Minute edits wrap within the minute field only; the minute carry
    // reaches HOUR only while the clock is running.
    assign min_inc  = sec_carry | ((mode_q == SET_MIN) & edit_up);
    assign min_dec  = (mode_q == SET_MIN) & edit_dn;
    assign hour_inc = (min_carry & (mode_q == NORMAL)) | ((mode_q == SET_HOUR) & edit_up);
    assign hour_dec = (mode_q == SET_HOUR) & edit_dn;

    mod_updown_cnt #(.MOD(SEC_MAX + 1), .W(6)) u_sec (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (tick),
        .dec   (1'b0),
        .clr   (sec_clr),
        .value (SEC),
        .carry (sec_carry)
    );

    mod_updown_cnt #(.MOD(MIN_MAX + 1), .W(6)) u_min (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (min_inc),
        .dec   (min_dec),
        .clr   (1'b0),
        .value (MIN),
        .carry (min_carry)
    );

    mod_updown_cnt #(.MOD(HOUR_MAX + 1), .W(5)) u_hour (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (hour_inc),
        .dec   (hour_dec),
        .clr   (1'b0),
        .value (HOUR),
        .carry (hour_carry_unused)
    );

    assign MODE  = mode_q;
    assign BLINK = blink_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl: scoreboard bench for time_set_ctrl at CLK_HZ=8.
// The driver applies BTN/RST on the falling edge, advances a time-of-day
// reference model (seconds since midnight plus cycle counters) and queues
// the expected outputs; a monitor pops one entry after every rising edge.
module tb_time_set_ctrl;

    localparam int C = 8;      // clock frequency used for the bench
    localparam int Q = C / 4;  // blink half-period in cycles

    localparam logic [2:0] B_NONE = 3'b000;
    localparam logic [2:0] B_MODE = 3'b001;
    localparam logic [2:0] B_UP   = 3'b010;
    localparam logic [2:0] B_DN   = 3'b100;

    logic       CLK;
    logic       RST;
    logic [2:0] BTN;
    logic [4:0] HOUR;
    logic [5:0] MIN;
    logic [5:0] SEC;
    logic [1:0] MODE;
    logic       BLINK;

    time_set_ctrl #(.CLK_HZ(C)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .BTN   (BTN),
        .HOUR  (HOUR),
        .MIN   (MIN),
        .SEC   (SEC),
        .MODE  (MODE),
        .BLINK (BLINK)
    );

    typedef struct {
        int h;
        int m;
        int s;
        int mode;
        int blink;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model state
    int t_sec;   // seconds since midnight
    int m_mode;  // 0 normal, 1 set hour, 2 set minute
    int n_run;   // cycles since the clock (re)started running
    int k_set;   // cycles since entering the current set mode

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    function automatic void cmp(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endfunction

    function automatic void model_edge(input logic [2:0] b, input logic r);
        int hh, mm, ss;
        bit mb, up, dn;
        if (r) begin
            t_sec  = 0;
            m_mode = 0;
            n_run  = 0;
            k_set  = 0;
            return;
        end
        mb = b[0];
        up = b[1] && !b[2];
        dn = b[2] && !b[1];
        hh = t_sec / 3600;
        mm = (t_sec / 60) % 60;
        ss = t_sec % 60;
        case (m_mode)
            0: begin
                if (n_run % C == C - 1) t_sec = (t_sec + 1) % 86400;
                if (mb) begin
                    m_mode = 1;
                    k_set  = 0;
                end else begin
                    n_run++;
                end
            end
            1: begin
                if (mb) begin
                    m_mode = 2;
                    k_set  = 0;
                end else begin
                    if (up) hh = (hh + 1) % 24;
                    if (dn) hh = (hh + 23) % 24;
                    t_sec = hh * 3600 + mm * 60 + ss;
                    k_set++;
                end
            end
            default: begin
                if (mb) begin
                    m_mode = 0;
                    t_sec  = hh * 3600 + mm * 60;
                    n_run  = 0;
                end else begin
                    if (up) mm = (mm + 1) % 60;
                    if (dn) mm = (mm + 59) % 60;
                    t_sec = hh * 3600 + mm * 60 + ss;
                    k_set++;
                end
            end
        endcase
    endfunction

    task automatic step(input logic [2:0] b, input logic r);
        exp_t e;
        @(negedge CLK);
        BTN = b;
        RST = r;
        model_edge(b, r);
        e.h     = t_sec / 3600;
        e.m     = (t_sec / 60) % 60;
        e.s     = t_sec % 60;
        e.mode  = m_mode;
        e.blink = (m_mode != 0 && ((k_set / Q) % 2) == 0) ? 1 : 0;
        exp_q.push_back(e);
    endtask

    // Wait until the edge of the last step has been applied and checked.
    task automatic settle();
        @(posedge CLK);
        #2;
    endtask

    // Raise RST between edges and check that the outputs clear at once.
    task automatic async_reset(input string tag);
        @(posedge CLK);
        #2;
        RST = 1'b1;
        #1;
        cmp({tag, "_async_hour"},  int'(HOUR),  0);
        cmp({tag, "_async_min"},   int'(MIN),   0);
        cmp({tag, "_async_sec"},   int'(SEC),   0);
        cmp({tag, "_async_mode"},  int'(MODE),  0);
        cmp({tag, "_async_blink"}, int'(BLINK), 0);
        step(B_NONE, 1'b1);
    endtask

    // Monitor: one expected entry per rising edge issued by the driver.
    always @(posedge CLK) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cmp("sb_hour",  int'(HOUR),  e.h);
            cmp("sb_min",   int'(MIN),   e.m);
            cmp("sb_sec",   int'(SEC),   e.s);
            cmp("sb_mode",  int'(MODE),  e.mode);
            cmp("sb_blink", int'(BLINK), e.blink);
        end
    end

    initial begin
        RST = 1'b1;
        BTN = B_NONE;
        model_edge(B_NONE, 1'b1);

        // Power-on reset, then the first second after release
        step(B_NONE, 1'b1);
        step(B_NONE, 1'b1);
        settle();
        cmp("reset_hour", int'(HOUR), 0);
        cmp("reset_mode", int'(MODE), 0);
        cmp("reset_blink", int'(BLINK), 0);
        step(B_NONE, 1'b0);
        repeat (6) step(B_NONE, 1'b0);
        settle();
        cmp("first_sec_not_early", int'(SEC), 0);
        step(B_NONE, 1'b0);
        settle();
        cmp("first_sec_on_time", int'(SEC), 1);
        repeat (12) step(B_NONE, 1'b0);

        // Set 23:59 by down-wrapping both fields, then roll over
        step(B_MODE, 1'b0);
        step(B_DN, 1'b0);
        settle();
        cmp("set_hour_down_wrap", int'(HOUR), 23);
        cmp("set_hour_mode", int'(MODE), 1);
        step(B_MODE, 1'b0);
        step(B_DN, 1'b0);
        settle();
        cmp("set_min_down_wrap", int'(MIN), 59);
        step(B_MODE, 1'b0);
        settle();
        cmp("exit_mode_normal", int'(MODE), 0);
        cmp("exit_sec_cleared", int'(SEC), 0);
        repeat (60 * C - 1) step(B_NONE, 1'b0);
        settle();
        cmp("roll_pre_sec", int'(SEC), 59);
        cmp("roll_pre_hour", int'(HOUR), 23);
        step(B_NONE, 1'b0);
        settle();
        cmp("roll_hour", int'(HOUR), 0);
        cmp("roll_min", int'(MIN), 0);
        cmp("roll_sec", int'(SEC), 0);

        // Hour wrap in both directions
        step(B_MODE, 1'b0);
        step(B_DN, 1'b0);
        settle();
        cmp("hour_dn_0_to_23", int'(HOUR), 23);
        step(B_UP, 1'b0);
        settle();
        cmp("hour_up_23_to_0", int'(HOUR), 0);
        step(B_DN, 1'b0);
        settle();
        cmp("hour_dn_again", int'(HOUR), 23);

        // MODE beats UP; UP+DOWN cancel; frozen clock and blink in SET_MIN
        step(B_MODE | B_UP, 1'b0);
        settle();
        cmp("prio_mode", int'(MODE), 2);
        cmp("prio_hour_kept", int'(HOUR), 23);
        cmp("prio_blink_start", int'(BLINK), 1);
        step(B_UP | B_DN, 1'b0);
        settle();
        cmp("updown_min_kept", int'(MIN), 0);
        cmp("blink_second_cycle", int'(BLINK), 1);
        step(B_NONE, 1'b0);
        settle();
        cmp("blink_toggled", int'(BLINK), 0);
        repeat (39) step(B_NONE, 1'b0);
        settle();
        cmp("freeze_sec", int'(SEC), 0);
        step(B_MODE, 1'b0);
        settle();
        cmp("normal_blink_low", int'(BLINK), 0);

        // UP/DOWN ignored while running
        step(B_UP, 1'b0);
        step(B_DN, 1'b0);
        step(B_UP | B_DN, 1'b0);
        settle();
        cmp("normal_ignore_hour", int'(HOUR), 23);
        cmp("normal_ignore_min", int'(MIN), 0);

        // Reset in the middle of an edit
        step(B_MODE, 1'b0);
        step(B_UP, 1'b0);
        settle();
        cmp("edit_before_reset", int'(HOUR), 0);
        async_reset("midedit");
        step(B_NONE, 1'b0);
        repeat (7) step(B_NONE, 1'b0);
        settle();
        cmp("after_reset_sec", int'(SEC), 1);
        cmp("after_reset_mode", int'(MODE), 0);

        // Randomised presses, first with busy then with sparse MODE
        for (int i = 0; i < 1500; i++) begin
            logic [2:0] b;
            int mode_odds;
            mode_odds = (i < 600) ? 9 : 39;
            b[0] = ($urandom_range(0, mode_odds) == 0);
            b[1] = ($urandom_range(0, 4) == 0);
            b[2] = ($urandom_range(0, 4) == 0);
            step(b, 1'b0);
            if (i == 1000) async_reset("random");
        end
        step(B_NONE, 1'b0);
        settle();
        #3;
        cmp("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
